wiscsc15_dmem_ctrl: RTL and testbench

WISCSC15_DMEM_CTRL -- requirements
Module: wiscsc15_dmem_ctrl

---
 rtl/wiscsc15_pkg.sv | 22 ++
 rtl/wiscsc15_dmem_array.sv | 33 +++
 rtl/wiscsc15_dmem_ctrl.sv | 121 ++++++++++++
 tb/tb_wiscsc15_dmem_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wiscsc15_pkg.sv
// rtl/wiscsc15_pkg.sv - shared types and constants for the wiscsc15 data-memory controller
package wiscsc15_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  // A simultaneous read+write request resolves to a write.
  function automatic op_t op_decode(input logic wr);
    return wr ? OP_WRITE : OP_READ;
  endfunction

endpackage

// File: rtl/wiscsc15_dmem_array.sv
// rtl/wiscsc15_dmem_array.sv - single-port synchronous RAM, write enable, registered read
module wiscsc15_dmem_array
  import wiscsc15_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**AW];

  // Storage is deliberately outside the reset domain so contents survive rst.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/wiscsc15_dmem_ctrl.sv
// rtl/wiscsc15_dmem_ctrl.sv - multi-cycle data-memory controller (IDLE/BUSY/DONE)
// Optional request checking with err output: WISCSC15_DMEM_ERR_EN
module wiscsc15_dmem_ctrl
  import wiscsc15_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int AW      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dm_read,
  input  logic              dm_write,
  input  logic [15:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              done
`ifdef WISCSC15_DMEM_ERR_EN
  ,
  output logic              err
`endif
);

  state_t            state;
  logic [2:0]        cnt;
  op_t               cap_op;
  logic [AW-1:0]     cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic              req;
  logic              mem_go;
  logic              mem_we;
  logic              mem_re;
  logic [15:0]       addr_hi;

  assign req     = dm_read | dm_write;
  assign addr_hi = addr >> AW;

`ifdef WISCSC15_DMEM_ERR_EN
  logic req_bad;
  assign req_bad = (dm_read & dm_write) | (addr_hi != 16'd0);
`else
  // Upper address bits alias onto the array in this build.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_hi;
`endif

  // The access fires on the edge that leaves the last BUSY cycle.
  assign mem_go = (state == ST_BUSY) && (cnt == 3'd0);
  assign mem_we = mem_go && (cap_op == OP_WRITE);
  assign mem_re = mem_go && (cap_op == OP_READ);

  assign stall = !rst && (((state == ST_IDLE) && req) || (state == ST_BUSY));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= 3'd0;
      cap_op    <= OP_READ;
      cap_addr  <= '0;
      cap_wdata <= '0;
      done      <= 1'b0;
`ifdef WISCSC15_DMEM_ERR_EN
      err       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef WISCSC15_DMEM_ERR_EN
      err  <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (req) begin
            cap_op    <= op_decode(dm_write);
            cap_addr  <= addr[AW-1:0];
            cap_wdata <= wdata;
`ifdef WISCSC15_DMEM_ERR_EN
            if (req_bad) begin
              state <= ST_DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state <= ST_BUSY;
              cnt   <= 3'(LATENCY - 1);
            end
`else
            state <= ST_BUSY;
            cnt   <= 3'(LATENCY - 1);
`endif
          end
        end
        ST_BUSY: begin
          if (cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
          end else begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  wiscsc15_dmem_array #(
    .AW(AW)
  ) u_array (
    .clk  (clk),
    .rst  (rst),
    .we   (mem_we),
    .re   (mem_re),
    .addr (cap_addr),
    .wdata(cap_wdata),
    .rdata(rdata)
  );

endmodule

// File: tb/tb_wiscsc15_dmem_ctrl.sv
// tb/tb_wiscsc15_dmem_ctrl.sv - directed bench with a request-schedule model for two latencies
module tb_wiscsc15_dmem_ctrl;

  localparam int LAT0 = 2;
  localparam int LAT1 = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd [2];
  logic        wr [2];
  logic [15:0] ad [2];
  logic [15:0] wd [2];
  logic [15:0] rdat [2];
  logic        stl [2];
  logic        dn [2];
`ifdef WISCSC15_DMEM_ERR_EN
  logic        er [2];
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  wiscsc15_dmem_ctrl #(.LATENCY(LAT0), .AW(8)) u_dut0 (
    .clk(clk), .rst(rst), .dm_read(rd[0]), .dm_write(wr[0]), .addr(ad[0]), .wdata(wd[0]),
    .rdata(rdat[0]), .stall(stl[0]), .done(dn[0])
`ifdef WISCSC15_DMEM_ERR_EN
    , .err(er[0])
`endif
  );

  wiscsc15_dmem_ctrl #(.LATENCY(LAT1), .AW(8)) u_dut1 (
    .clk(clk), .rst(rst), .dm_read(rd[1]), .dm_write(wr[1]), .addr(ad[1]), .wdata(wd[1]),
    .rdata(rdat[1]), .stall(stl[1]), .done(dn[1])
`ifdef WISCSC15_DMEM_ERR_EN
    , .err(er[1])
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Schedule model: an accepted request completes a fixed number of cycles later.
  logic [15:0] mm [2][256];
  bit          kn [2][256];
  bit          act [2];
  bit          pw [2];
  bit          perr [2];
  logic [7:0]  pa [2];
  logic [15:0] pd [2];
  int          dcyc [2];
  logic [15:0] rm [2];
  bit          rk [2];
  int          cyc_n = 0;

  always @(negedge clk) begin
    cyc_n++;
    for (int k = 0; k < 2; k++) begin
      bit e_done;
      bit e_stall;
      bit e_err;
      int lat;
      lat = (k == 0) ? LAT0 : LAT1;
      e_done = 0;
      e_stall = 0;
      e_err = 0;
      if (rst) begin
        act[k] = 0;
        rm[k] = 16'h0000;
        rk[k] = 1;
      end else if (act[k] && cyc_n == dcyc[k]) begin
        e_done = 1;
        e_err = perr[k];
        if (!perr[k]) begin
          if (pw[k]) begin
            mm[k][pa[k]] = pd[k];
            kn[k][pa[k]] = 1;
          end else begin
            rm[k] = mm[k][pa[k]];
            rk[k] = kn[k][pa[k]];
          end
        end
        act[k] = 0;
      end else begin
        if (!act[k] && (rd[k] || wr[k])) begin
          pw[k] = wr[k];
          pa[k] = ad[k][7:0];
          pd[k] = wd[k];
`ifdef WISCSC15_DMEM_ERR_EN
          perr[k] = (rd[k] && wr[k]) || (ad[k][15:8] != 8'h00);
`else
          perr[k] = 0;
`endif
          dcyc[k] = cyc_n + (perr[k] ? 1 : lat + 1);
          act[k] = 1;
        end
        e_stall = act[k];
      end
      chk($sformatf("stall%0d@%0d", k, cyc_n), {31'b0, stl[k]}, {31'b0, e_stall});
      chk($sformatf("done%0d@%0d", k, cyc_n), {31'b0, dn[k]}, {31'b0, e_done});
      if (rk[k]) chk($sformatf("rdata%0d@%0d", k, cyc_n), {16'b0, rdat[k]}, {16'b0, rm[k]});
`ifdef WISCSC15_DMEM_ERR_EN
      chk($sformatf("err%0d@%0d", k, cyc_n), {31'b0, er[k]}, {31'b0, e_err});
`else
      if (e_err) chk("model_err", 32'd1, 32'd0);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for done (bounded), dropping the request after its first cycle.
  task automatic wait_done(input int k, output int cyc, output logic [15:0] rv);
    cyc = 0;
    rv = 16'h0000;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (dn[k]) begin
        cyc = i;
        rv = rdat[k];
        break;
      end
      @(posedge clk);
      #1;
      rd[k] = 1'b0;
      wr[k] = 1'b0;
    end
    if (cyc == 0) chk("done_timeout", 32'd0, 32'd1);
    tick();
  endtask

  task automatic access(input int k, input logic r, input logic w, input logic [15:0] a,
                        input logic [15:0] d, output int cyc, output logic [15:0] rv);
    rd[k] = r;
    wr[k] = w;
    ad[k] = a;
    wd[k] = d;
    wait_done(k, cyc, rv);
  endtask

  initial begin
    int c;
    int c2;
    int t1;
    int t2;
    int npulse;
    logic [15:0] rv;
    logic [15:0] exp_rv;
    bit exp_s [4];
    bit exp_d [4];
    for (int k = 0; k < 2; k++) begin
      rd[k] = 0; wr[k] = 0; ad[k] = 0; wd[k] = 0;
    end
    exp_s = '{1, 1, 1, 0};
    exp_d = '{0, 0, 0, 1};

    #1 rst = 1'b1;
    #1;
    chk("rst_rdata", {16'b0, rdat[0]}, 32'h0);
    chk("rst_stall", {31'b0, stl[0]}, 32'h0);
    chk("rst_done", {31'b0, dn[0]}, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Write 0xBEEF to 5: three stall cycles, done in the fourth.
    wr[0] = 1; ad[0] = 16'h0005; wd[0] = 16'hBEEF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("w5_stall_c%0d", i + 1), {31'b0, stl[0]}, {31'b0, exp_s[i]});
      chk($sformatf("w5_done_c%0d", i + 1), {31'b0, dn[0]}, {31'b0, exp_d[i]});
      tick();
      if (i == 0) wr[0] = 0;
    end
    access(0, 1, 0, 16'h0005, 16'h0000, c, rv);
    chk("r5_latency", c, 32'd4);
    chk("r5_rdata", {16'b0, rv}, 32'h0000BEEF);

    // Inputs changed during BUSY must not affect the access.
    wr[0] = 1; ad[0] = 16'h0020; wd[0] = 16'h1111;
    tick();
    wr[0] = 0; ad[0] = 16'h0021; wd[0] = 16'h2222;
    wait_done(0, c, rv);
    access(0, 1, 0, 16'h0020, 16'h0000, c, rv);
    chk("capture_rdata", {16'b0, rv}, 32'h00001111);
    access(0, 0, 1, 16'h0030, 16'h3333, c, rv);
    chk("hold_after_write", {16'b0, rdat[0]}, 32'h00001111);

    // LATENCY=1 back-to-back reads with dm_read held high.
    access(1, 0, 1, 16'h0001, 16'hC001, c, rv);
    access(1, 0, 1, 16'h0002, 16'hC002, c, rv);
    rd[1] = 1; ad[1] = 16'h0001;
    t1 = 0; t2 = 0; npulse = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (dn[1]) begin
        npulse++;
        if (t1 == 0) begin
          t1 = i;
          chk("b2b_rd1", {16'b0, rdat[1]}, 32'h0000C001);
          #1 ad[1] = 16'h0002;
        end else if (t2 == 0) begin
          t2 = i;
          chk("b2b_rd2", {16'b0, rdat[1]}, 32'h0000C002);
          #1 rd[1] = 0;
        end
      end
    end
    chk("b2b_gap", t2 - t1, 32'd3);
    chk("b2b_pulses", npulse, 32'd2);
    tick();

    // Reset in the second BUSY cycle aborts the write.
    access(0, 0, 1, 16'h0010, 16'h5678, c, rv);
    wr[0] = 1; ad[0] = 16'h0010; wd[0] = 16'h1234;
    tick();
    wr[0] = 0;
    tick();
    rst = 1'b1;
    #1;
    chk("abort_rdata", {16'b0, rdat[0]}, 32'h0);
    chk("abort_stall", {31'b0, stl[0]}, 32'h0);
    chk("abort_done", {31'b0, dn[0]}, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    access(0, 1, 0, 16'h0010, 16'h0000, c, rv);
    chk("abort_keep", {16'b0, rv}, 32'h00005678);

`ifdef WISCSC15_DMEM_ERR_EN
    access(0, 0, 1, 16'h0003, 16'h7777, c, rv);
    access(0, 1, 1, 16'h0003, 16'h9999, c, rv);
    chk("err_rw_latency", c, 32'd2);
    access(0, 1, 0, 16'h0003, 16'h0000, c, rv);
    chk("err_mem_unchanged", {16'b0, rv}, 32'h00007777);
    access(0, 1, 0, 16'h0100, 16'h0000, c, rv);
    chk("err_hiaddr_latency", c, 32'd2);
    exp_rv = 16'h7777;
`else
    access(0, 0, 1, 16'h0103, 16'hA5A5, c, rv);
    access(0, 1, 0, 16'h0003, 16'h0000, c, rv);
    chk("alias_rdata", {16'b0, rv}, 32'h0000A5A5);
    access(0, 1, 1, 16'h0004, 16'h4444, c, rv);
    access(0, 1, 0, 16'h0004, 16'h0000, c2, rv);
    chk("rw_as_write", {16'b0, rv}, 32'h00004444);
    exp_rv = 16'h4444;
`endif
    tick();
    tick();
    chk("final_hold", {16'b0, rdat[0]}, {16'b0, exp_rv});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
